// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider-sharing controller and its iterative core.
package div_ctrl_pkg;

   localparam int DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      RESP = 2'd3
   } state_t;

   // Zero-divisor quotient pattern; sliced to the operand width at use.
   localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_core_iter.sv
// Unsigned restoring divider: one quotient bit per clock, DATA_W iterations after i_start,
// then a one-cycle o_done pulse with quotient/remainder held until the next start.
module div_core_iter
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_dvd,
   input  logic [DATA_W-1:0] i_dvs,
   output logic              o_done,
   output logic [DATA_W-1:0] o_quot,
   output logic [DATA_W-1:0] o_rem
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic              r_run;
   logic              r_done;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_quot;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_dvs;

   logic [DATA_W:0]   w_shift;
   logic [DATA_W-1:0] w_diff;
   logic              w_ge;

   // The dividend shifts out of r_quot as quotient bits shift in.
   assign w_shift = {r_rem, r_quot[DATA_W-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dvs});
   assign w_diff  = w_shift[DATA_W-1:0] - r_dvs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run  <= 1'b0;
         r_done <= 1'b0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dvs  <= '0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_run  <= 1'b1;
            r_cnt  <= '0;
            r_quot <= i_dvd;
            r_rem  <= '0;
            r_dvs  <= i_dvs;
         end else if (r_run) begin
            r_quot <= {r_quot[DATA_W-2:0], w_ge};
            r_rem  <= w_ge ? w_diff : w_shift[DATA_W-1:0];
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(DATA_W-1)) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_done = r_done;
   assign o_quot = r_quot;
   assign o_rem  = r_rem;

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin front end sharing one iterative signed divider among NUM_REQ requesters.
// Build option DIV_ZERO_ERR_EN adds the rsp_err divide-by-zero flag.
module div_share_ctrl
   import div_ctrl_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = DEF_DATA_W,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
   input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_quotient,
   output logic [DATA_W-1:0]         rsp_remainder,
`ifdef DIV_ZERO_ERR_EN
   output logic                      rsp_err,
`endif
   output logic                      busy
);

   state_t            r_state, w_next;
   logic [ID_W-1:0]   r_rr, r_id, w_win;
   logic              w_any, w_accept, w_dvs_zero, w_start, w_core_done;
   logic [DATA_W-1:0] w_dvd, w_dvs, w_mag_dvd, w_mag_dvs;
   logic [DATA_W-1:0] r_dividend, r_quot, r_rem;
   logic              r_dvs_neg, r_div0;
   logic [DATA_W-1:0] w_core_quot, w_core_rem;

   // Round-robin pick: first valid requester at or after the pointer.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_any && req_valid[(int'(r_rr) + k) % NUM_REQ]) begin
            w_any = 1'b1;
            w_win = ID_W'((int'(r_rr) + k) % NUM_REQ);
         end
      end
   end

   assign w_accept   = (r_state == IDLE) && w_any;
   assign w_dvd      = req_dividend[int'(w_win)*DATA_W +: DATA_W];
   assign w_dvs      = req_divisor[int'(w_win)*DATA_W +: DATA_W];
   assign w_dvs_zero = (w_dvs == '0);
   assign w_mag_dvd  = w_dvd[DATA_W-1] ? (~w_dvd + 1'b1) : w_dvd;
   assign w_mag_dvs  = w_dvs[DATA_W-1] ? (~w_dvs + 1'b1) : w_dvs;
   assign w_start    = w_accept && !w_dvs_zero;

   always_comb begin
      req_ready = '0;
      if (w_accept) req_ready[w_win] = 1'b1;
   end

   div_core_iter #(.DATA_W(DATA_W)) u_core (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .i_dvd   (w_mag_dvd),
      .i_dvs   (w_mag_dvs),
      .o_done  (w_core_done),
      .o_quot  (w_core_quot),
      .o_rem   (w_core_rem)
   );

   // A zero divisor skips the core but still passes through FIX to load its constant result.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_next = w_dvs_zero ? FIX : BUSY;
         BUSY: if (w_core_done) w_next = FIX;
         FIX:  w_next = RESP;
         RESP: if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_rr       <= '0;
         r_id       <= '0;
         r_dividend <= '0;
         r_dvs_neg  <= 1'b0;
         r_div0     <= 1'b0;
         r_quot     <= '0;
         r_rem      <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_id       <= w_win;
            r_rr       <= (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
            r_dividend <= w_dvd;
            r_dvs_neg  <= w_dvs[DATA_W-1];
            r_div0     <= w_dvs_zero;
         end
         if (r_state == FIX) begin
            if (r_div0) begin
               r_quot <= DIV0_QUOT[DATA_W-1:0];
               r_rem  <= r_dividend;
            end else begin
               // Truncating division: remainder follows the dividend's sign.
               r_quot <= (r_dividend[DATA_W-1] ^ r_dvs_neg) ? (~w_core_quot + 1'b1) : w_core_quot;
               r_rem  <= r_dividend[DATA_W-1] ? (~w_core_rem + 1'b1) : w_core_rem;
            end
         end
      end
   end

`ifdef DIV_ZERO_ERR_EN
   logic r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (r_state == FIX) begin
         r_err <= r_div0;
      end else if ((r_state == RESP) && rsp_ready) begin
         r_err <= 1'b0;
      end
   end

   assign rsp_err = r_err;
`endif

   assign rsp_valid     = (r_state == RESP);
   assign rsp_id        = r_id;
   assign rsp_quotient  = r_quot;
   assign rsp_remainder = r_rem;
   assign busy          = (r_state != IDLE);

endmodule
